// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard / pipeline-control unit: scoreboard entry, control
// priority encoding and the forwarding-select constant.
package hazard_pkg;

  // Scoreboard rd field is sized for the widest supported register address;
  // narrower addresses are zero-extended on write and compare.
  localparam int unsigned MAX_REG_AW = 8;

  // fwd_sel value meaning "take the operand from the register file".
  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  is_load;
  } sb_entry_t;

  // Control modes, one per priority level.
  typedef enum logic [1:0] {
    CtlNone   = 2'd0,
    CtlHazard = 2'd1,
    CtlFlush  = 2'd2,
    CtlFreeze = 2'd3
  } ctl_mode_e;

  // Busywait beats a taken branch, which beats a decode hazard.
  function automatic ctl_mode_e ctl_priority(input logic busy, input logic branch,
                                             input logic hazard);
    if (busy)        return CtlFreeze;
    else if (branch) return CtlFlush;
    else if (hazard) return CtlHazard;
    else             return CtlNone;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode / control bundle between the pipeline and the hazard unit.
// master = pipeline side (drives decode state), slave = hazard unit.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned FW = $clog2(STAGES + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_wen;
  logic              id_is_load;
  logic              branch_taken;
  logic              mem_busywait;
  logic              freeze;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              bubble_ex;
  logic [FW-1:0]     fwd_sel_rs1;
  logic [FW-1:0]     fwd_sel_rs2;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wen, id_is_load,
    output branch_taken, mem_busywait,
    input  freeze, stall_pc, stall_if_id, flush_if_id, bubble_ex,
    input  fwd_sel_rs1, fwd_sel_rs2, stall_cycles, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wen, id_is_load,
    input  branch_taken, mem_busywait,
    output freeze, stall_pc, stall_if_id, flush_if_id, bubble_ex,
    output fwd_sel_rs1, fwd_sel_rs2, stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_match.sv
// hazard_match: youngest scoreboard entry whose destination equals one source operand.
// x0 and unused operands never match.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned IW     = $clog2(STAGES + 1)
) (
  input  sb_entry_t         sb [STAGES],
  input  logic              used,
  input  logic [REG_AW-1:0] rs,
  output logic              hit,
  output logic [IW-1:0]     idx,
  output logic              is_load
);

  // Scan oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    if (used && (rs != '0)) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (sb[i].valid && (sb[i].rd == MAX_REG_AW'(rs))) begin
          hit     = 1'b1;
          idx     = IW'(i);
          is_load = sb[i].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard-based hazard detection, stall/flush/freeze generation,
// forwarding selects and saturating stall/flush counters.
// Optional feature macro HAZARD_FWD_EN: when defined, forwarding is used and only
// load-use stalls; when undefined every RAW match stalls and fwd_sel is tied 0.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned FW = $clog2(STAGES + 1);

  sb_entry_t        sb_q [STAGES];
  sb_entry_t        new_entry;
  logic             hit1, hit2, ld1, ld2, haz1, haz2, hazard;
  logic [FW-1:0]    idx1, idx2;
  ctl_mode_e        mode;
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  hazard_match #(.STAGES(STAGES), .REG_AW(REG_AW), .IW(FW)) u_match_rs1 (
    .sb      (sb_q),
    .used    (bus.id_valid & bus.id_rs1_used),
    .rs      (bus.id_rs1),
    .hit     (hit1),
    .idx     (idx1),
    .is_load (ld1)
  );

  hazard_match #(.STAGES(STAGES), .REG_AW(REG_AW), .IW(FW)) u_match_rs2 (
    .sb      (sb_q),
    .used    (bus.id_valid & bus.id_rs2_used),
    .rs      (bus.id_rs2),
    .hit     (hit2),
    .idx     (idx2),
    .is_load (ld2)
  );

`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded.
  assign haz1 = hit1 && (idx1 == '0) && ld1;
  assign haz2 = hit2 && (idx2 == '0) && ld2;
  assign bus.fwd_sel_rs1 = (hit1 && !haz1) ? idx1 + FW'(1) : FW'(FWD_REGFILE);
  assign bus.fwd_sel_rs2 = (hit2 && !haz2) ? idx2 + FW'(1) : FW'(FWD_REGFILE);
`else
  assign haz1 = hit1;
  assign haz2 = hit2;
  assign bus.fwd_sel_rs1 = FW'(FWD_REGFILE);
  assign bus.fwd_sel_rs2 = FW'(FWD_REGFILE);
  logic unused_match;
  assign unused_match = ^{idx1, idx2, ld1, ld2};
`endif

  assign hazard = haz1 | haz2;
  assign mode   = ctl_priority(bus.mem_busywait, bus.branch_taken, hazard);

  // Decode control outputs from the winning priority level.
  always_comb begin
    bus.freeze      = 1'b0;
    bus.stall_pc    = 1'b0;
    bus.stall_if_id = 1'b0;
    bus.flush_if_id = 1'b0;
    bus.bubble_ex   = 1'b0;
    unique case (mode)
      CtlFreeze: begin
        bus.freeze      = 1'b1;
        bus.stall_pc    = 1'b1;
        bus.stall_if_id = 1'b1;
      end
      CtlFlush: begin
        bus.flush_if_id = 1'b1;
        bus.bubble_ex   = 1'b1;
      end
      CtlHazard: begin
        bus.stall_pc    = 1'b1;
        bus.stall_if_id = 1'b1;
        bus.bubble_ex   = 1'b1;
      end
      default: ;
    endcase
  end

  // Entry that decode would push into EX when it advances.
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = bus.id_valid & bus.id_wen & (bus.id_rd != '0);
    new_entry.rd      = MAX_REG_AW'(bus.id_rd);
    new_entry.is_load = bus.id_is_load;
  end

  // Scoreboard shift; bubble or flush inserts an invalid entry, freeze holds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sb_q[i] <= '0;
    end else if (mode != CtlFreeze) begin
      for (int i = STAGES - 1; i > 0; i--) sb_q[i] <= sb_q[i-1];
      sb_q[0] <= (mode == CtlNone) ? new_entry : '0;
    end
  end

  // Saturating performance counters; frozen cycles never count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (mode == CtlHazard && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (mode == CtlFlush && flush_count_q != '1) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (STAGES=3). Expectations follow the
// HAZARD_FWD_EN build selection.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned STAGES = 3;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  // {freeze, stall_pc, stall_if_id, flush_if_id, bubble_ex}
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_HAZARD = 5'b01101;
  localparam logic [4:0] C_FLUSH  = 5'b00011;
  localparam logic [4:0] C_FREEZE = 5'b11100;

`ifdef HAZARD_FWD_EN
  localparam int LU_STALLS = 1;
`else
  localparam int LU_STALLS = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_hazard_ctrl_if #(.STAGES(STAGES), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.STAGES(STAGES), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [4:0] ctl;
  assign ctl = {bus.freeze, bus.stall_pc, bus.stall_if_id, bus.flush_if_id, bus.bubble_ex};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_wen      = wen;
    bus.id_is_load  = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    bus.branch_taken = 1'b0;
    bus.mem_busywait = 1'b0;
    idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.branch_taken = 1'b0;
    bus.mem_busywait = 1'b1;
    idle();
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_FREEZE) begin
      n_fail++; $display("FAIL reset_busy_ctl: got %b want %b", ctl, C_FREEZE);
    end
    bus.mem_busywait = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE);
    end
    n_checks++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_count);
    end
    n_checks++;
    if (bus.fwd_sel_rs1 !== '0 || bus.fwd_sel_rs2 !== '0) begin
      n_fail++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", bus.fwd_sel_rs1, bus.fwd_sel_rs2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5,x1,x2
    n_checks++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL b2b_first_ctl: got %b want %b", ctl, C_NONE);
    end
    tick();
    drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);  // add x7,x5,x1
`ifdef HAZARD_FWD_EN
    n_checks++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL b2b_ctl: got %b want %b", ctl, C_NONE);
    end
    n_checks++;
    if (bus.fwd_sel_rs1 !== 2'd1 || bus.fwd_sel_rs2 !== 2'd0) begin
      n_fail++; $display("FAIL b2b_fwd: got %0d/%0d want 1/0", bus.fwd_sel_rs1, bus.fwd_sel_rs2);
    end
    tick();
    idle();
    n_checks++;
    if (bus.stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL b2b_stall_cnt: got %0d want 0", bus.stall_cycles);
    end
`else
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ctl !== C_HAZARD || bus.fwd_sel_rs1 !== 2'd0) begin
        n_fail++; $display("FAIL b2b_stall%0d: ctl %b fwd %0d want %b fwd 0", i, ctl,
                           bus.fwd_sel_rs1, C_HAZARD);
      end
      tick();
    end
    n_checks++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL b2b_release: got %b want %b", ctl, C_NONE);
    end
    tick();
    idle();
    n_checks++;
    if (bus.stall_cycles !== 32'd3) begin
      n_fail++; $display("FAIL b2b_stall_cnt: got %0d want 3", bus.stall_cycles);
    end
`endif
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);  // lw x6
    tick();
    drive(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);  // add x8,x6,x6
    for (int i = 0; i < LU_STALLS; i++) begin
      n_checks++;
      if (ctl !== C_HAZARD) begin
        n_fail++; $display("FAIL lu_bubble%0d: got %b want %b", i, ctl, C_HAZARD);
      end
      tick();
    end
    n_checks++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL lu_release: got %b want %b", ctl, C_NONE);
    end
`ifdef HAZARD_FWD_EN
    n_checks++;
    if (bus.fwd_sel_rs1 !== 2'd2 || bus.fwd_sel_rs2 !== 2'd2) begin
      n_fail++; $display("FAIL lu_fwd: got %0d/%0d want 2/2", bus.fwd_sel_rs1, bus.fwd_sel_rs2);
    end
`else
    n_checks++;
    if (bus.fwd_sel_rs1 !== 2'd0 || bus.fwd_sel_rs2 !== 2'd0) begin
      n_fail++; $display("FAIL lu_fwd: got %0d/%0d want 0/0", bus.fwd_sel_rs1, bus.fwd_sel_rs2);
    end
`endif
    tick();
    idle();
    n_checks++;
    if (bus.stall_cycles !== 32'(LU_STALLS)) begin
      n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", bus.stall_cycles, LU_STALLS);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);  // lw x6
    tick();
    drive(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    bus.branch_taken = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_FLUSH) begin
      n_fail++; $display("FAIL br_ctl: got %b want %b", ctl, C_FLUSH);
    end
    tick();
    bus.branch_taken = 1'b0;
    idle();
    n_checks++;
    if (bus.flush_count !== 32'd1 || bus.stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL br_cnt: flush %0d stall %0d want 1/0", bus.flush_count,
                         bus.stall_cycles);
    end
  endtask

  task automatic test_busywait();
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);  // lw x6
    tick();
    drive(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    bus.mem_busywait = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ctl !== C_FREEZE) begin
        n_fail++; $display("FAIL bw_freeze%0d: got %b want %b", i, ctl, C_FREEZE);
      end
      tick();
    end
    n_checks++;
    if (bus.stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL bw_cnt_hold: got %0d want 0", bus.stall_cycles);
    end
    bus.mem_busywait = 1'b0;
    #1;
    for (int i = 0; i < LU_STALLS; i++) begin
      n_checks++;
      if (ctl !== C_HAZARD) begin
        n_fail++; $display("FAIL bw_bubble%0d: got %b want %b", i, ctl, C_HAZARD);
      end
      tick();
    end
    n_checks++;
    if (ctl !== C_NONE || bus.stall_cycles !== 32'(LU_STALLS)) begin
      n_fail++; $display("FAIL bw_after: ctl %b cnt %0d want %b cnt %0d", ctl, bus.stall_cycles,
                         C_NONE, LU_STALLS);
    end
    tick();
  endtask

  task automatic test_busy_branch();
    do_reset();
    bus.mem_busywait = 1'b1;
    bus.branch_taken = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_FREEZE) begin
      n_fail++; $display("FAIL bb_freeze: got %b want %b", ctl, C_FREEZE);
    end
    tick();
    n_checks++;
    if (bus.flush_count !== 32'd0) begin
      n_fail++; $display("FAIL bb_cnt_hold: got %0d want 0", bus.flush_count);
    end
    bus.mem_busywait = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_FLUSH) begin
      n_fail++; $display("FAIL bb_flush: got %b want %b", ctl, C_FLUSH);
    end
    tick();
    bus.branch_taken = 1'b0;
    #1;
    n_checks++;
    if (bus.flush_count !== 32'd1) begin
      n_fail++; $display("FAIL bb_cnt: got %0d want 1", bus.flush_count);
    end
  endtask

  task automatic test_x0_and_idle();
    do_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw x0 (discarded)
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);  // add x9,x0,x0
    n_checks++;
    if (ctl !== C_NONE || bus.fwd_sel_rs1 !== 2'd0 || bus.fwd_sel_rs2 !== 2'd0) begin
      n_fail++; $display("FAIL x0: ctl %b fwd %0d/%0d want 0", ctl, bus.fwd_sel_rs1,
                         bus.fwd_sel_rs2);
    end
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);  // lw x5
    tick();
    drive(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // invalid slot reading x5
    n_checks++;
    if (ctl !== C_NONE || bus.fwd_sel_rs1 !== 2'd0 || bus.fwd_sel_rs2 !== 2'd0) begin
      n_fail++; $display("FAIL idle: ctl %b fwd %0d/%0d want 0", ctl, bus.fwd_sel_rs1,
                         bus.fwd_sel_rs2);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);  // lw x6
    tick();
    drive(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    for (int i = 0; i < LU_STALLS; i++) tick();
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1);  // lw x10
    tick();
    drive(1'b1, 5'd10, 5'd1, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);  // add x11,x10,x1
    n_checks++;
    if (ctl !== C_HAZARD || bus.stall_cycles !== 32'(LU_STALLS)) begin
      n_fail++; $display("FAIL rms_before: ctl %b cnt %0d want %b cnt %0d", ctl,
                         bus.stall_cycles, C_HAZARD, LU_STALLS);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_NONE || bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0) begin
      n_fail++; $display("FAIL rms_clear: ctl %b cnt %0d/%0d want 0", ctl, bus.stall_cycles,
                         bus.flush_count);
    end
    rst = 1'b0;
    #1;
    tick();
    n_checks++;
    if (ctl !== C_NONE || bus.stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL rms_issue: ctl %b cnt %0d want 0", ctl, bus.stall_cycles);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_busywait();
    test_busy_branch();
    test_x0_and_idle();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and pipeline-control unit for the in-order RISC-V core. It tracks every in-flight register write in a per-stage scoreboard and generates PC/IF-ID stall, IF-ID flush, ID-EX bubble and whole-pipe freeze. It produces operand forwarding selects for decode and keeps saturating stall and flush counters. It replaces the ad-hoc busywait and branch gating currently wired separately into each pipeline register.

## Interface
- STAGES, 3, number of post-decode stages holding an uncommitted write (entry 0 = EX, STAGES-1 = last before regfile write)
- REG_AW, 5, register address width
- CNT_W, 32, width of performance counters
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears scoreboard and counters
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source registers of decode instruction
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_AW  destination register
- id_wen  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load (result available only after MEM)
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_busywait  in  1  OR of instruction- and data-cache busywait
- freeze  out  1  hold every pipeline register and the PC
- stall_pc, stall_if_id  out  1  hold PC and IF/ID register
- flush_if_id  out  1  load a NOP into IF/ID
- bubble_ex  out  1  load a NOP into ID/EX
- fwd_sel_rs1, fwd_sel_rs2  out  $clog2(STAGES+1)  0 = regfile, k = result of scoreboard entry k-1
- stall_cycles, flush_count  out  CNT_W  performance counters

## Operation
- Scoreboard: STAGES entries {valid, rd, is_load}. Reset: all valid=0.
- Match: an operand matches when it is used, rs != 0, and an entry is valid with rd == rs. The youngest entry (lowest index) wins.
- Hazard with HAZARD_FWD_EN: hazard only if the winning entry is index 0 with is_load=1 (load-use). Otherwise fwd_sel = index+1.
- Hazard without HAZARD_FWD_EN: any match is a hazard, and fwd_sel is always 0.
- Decode is ignored when id_valid=0 (no hazard, fwd_sel=0).
- Outputs are combinational, evaluated in priority order:
  - mem_busywait: freeze=1, stall_pc=1, stall_if_id=1, flush/bubble=0. Scoreboard and counters hold.
  - branch_taken: flush_if_id=1, bubble_ex=1, stalls=0. The decode hazard is ignored because the instruction is wrong-path.
  - hazard: stall_pc=1, stall_if_id=1, bubble_ex=1.
  - otherwise: all control outputs 0.
- Scoreboard update at the rising edge when not frozen:
  - shift entry i to entry i+1, and the last entry retires;
  - entry 0 <= {id_valid & id_wen & (id_rd != 0), id_rd, id_is_load} when advancing;
  - entry 0 <= invalid on bubble or flush.
- Counters:
  - stall_cycles increments on each unfrozen hazard cycle;
  - flush_count increments on each unfrozen branch_taken cycle;
  - both saturate at all-ones.

## Timing
- Forwarding and stall decisions are valid in the same cycle as the decode inputs. The scoreboard changes only at the clk edge.
- Load-use penalty with forwarding: exactly 1 bubble. The next cycle the load sits in entry 1 and fwd_sel=2.
- Penalty without forwarding for a match at index i: STAGES-i stall cycles. The regfile writes at the edge, so the value is readable the cycle after retire.
- Busywait and branch_taken together: freeze wins, and the flush is taken on the first cycle busywait drops.
- Reset mid-stall: scoreboard and counters clear immediately, independent of clk, and outputs drop to 0 unless mem_busywait is high.
- With id_valid=0 and mem_busywait=0, all control outputs are 0 and all fwd_sel are 0.

## Configuration
- HAZARD_FWD_EN defined: forwarding paths are used, and only load-use stalls.
- HAZARD_FWD_EN undefined: fwd_sel outputs are tied 0, and every RAW match stalls until the producer retires.

## Structure
- Package hazard_pkg:
  - sb_entry_t struct {valid, rd, is_load};
  - FWD_REGFILE = 0;
  - priority encoding constants.
- Sub-module hazard_match: finds the youngest match for one operand and returns {hit, index, is_load}. It is instantiated twice, once per source operand.

## Test plan
- Back-to-back dependency, STAGES=3:
  - add x5 then add x7,x5,x1;
  - FWD_EN: no stall, fwd_sel_rs1=1;
  - no FWD_EN: 3 stall cycles, stall_cycles=3.
- Load-use: lw x6 then add x8,x6,x6 -> one cycle of bubble_ex=1, then fwd_sel_rs1=fwd_sel_rs2=2, stall_cycles=1.
- Branch over hazard: branch_taken=1 while decode has a load-use dependency -> flush_if_id=1, bubble_ex=1, stall_pc=0, flush_count=1, stall_cycles=0.
- Busywait 4 cycles during load-use:
  - freeze=1 for 4 cycles;
  - scoreboard and counters unchanged;
  - afterwards exactly 1 bubble.
- x0 handling: in-flight write with rd=0 and a decode reading x0 -> no stall, fwd_sel=0, entry stays invalid.
- Reset mid-stall, asserted between edges:
  - scoreboard empties and counters read 0 at once;
  - the dependent instruction issues without stall after release.
